// File: rtl/linear_network_unicast_sched.sv
// Round-robin scheduler sharing one linear unicast network injection port among NUM_REQ requesters.
// One-cycle issue latency; a stall reaches o_net_en one cycle late, and out-of-range destinations are consumed and flagged.
module linear_network_unicast_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_NODE   = 4,
  parameter int NUM_REQ    = 4,
  localparam int COMMAND_WIDTH = $clog2(NUM_NODE),
  localparam int REQ_ID_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_req_data,
  input  logic [NUM_REQ*COMMAND_WIDTH-1:0] i_req_dest,
  output logic [NUM_REQ-1:0]               o_req_ready,
  input  logic                             i_stall,
  output logic                             o_net_valid,
  output logic [DATA_WIDTH-1:0]            o_net_data,
  output logic [COMMAND_WIDTH-1:0]         o_net_cmd,
  output logic                             o_net_en,
  output logic [REQ_ID_WIDTH-1:0]          o_grant_id,
  output logic                             o_err,
  output logic [15:0]                      o_issue_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

  state_t                    state_q, state_d;
  logic [REQ_ID_WIDTH-1:0]   ptr_q, ptr_d;
  logic                      net_valid_q, net_valid_d;
  logic [DATA_WIDTH-1:0]     net_data_q, net_data_d;
  logic [COMMAND_WIDTH-1:0]  net_cmd_q, net_cmd_d;
  logic                      net_en_q, net_en_d;
  logic [REQ_ID_WIDTH-1:0]   grant_q, grant_d;
  logic                      err_q, err_d;
  logic [15:0]               cnt_q, cnt_d;

  logic                      found;
  logic [REQ_ID_WIDTH-1:0]   win;
  logic                      load;
  logic                      xfer;
  logic [DATA_WIDTH-1:0]     win_data;
  logic [COMMAND_WIDTH-1:0]  win_dest;

  // Rotating priority search starting at the pointer.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && i_req_valid[idx]) begin
        found = 1'b1;
        win   = REQ_ID_WIDTH'(idx);
      end
    end
  end

  assign win_data    = i_req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
  assign win_dest    = i_req_dest[int'(win)*COMMAND_WIDTH +: COMMAND_WIDTH];
  assign xfer        = net_valid_q & net_en_q;
  assign load        = ~i_stall & (~net_valid_q | net_en_q);
  assign o_req_ready = (found && load && !rst) ? (NUM_REQ'(1) << win) : '0;

  always_comb begin
    ptr_d       = ptr_q;
    net_valid_d = net_valid_q;
    net_data_d  = net_data_q;
    net_cmd_d   = net_cmd_q;
    grant_d     = grant_q;
    err_d       = 1'b0;
    net_en_d    = ~i_stall;
    cnt_d       = cnt_q + 16'(xfer);
    state_d     = state_q;

    // A delivered packet leaves zero dummy data behind unless replaced below.
    if (xfer) begin
      net_valid_d = 1'b0;
      net_data_d  = '0;
      net_cmd_d   = '0;
    end

    if (load && found) begin
      ptr_d = (win == REQ_ID_WIDTH'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      if (int'(win_dest) < NUM_NODE) begin
        net_valid_d = 1'b1;
        net_data_d  = win_data;
        net_cmd_d   = win_dest;
        grant_d     = win;
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      IDLE:    state_d = net_valid_d ? SEND : IDLE;
      default: state_d = !net_valid_d ? IDLE : (i_stall ? HOLD : SEND);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      net_valid_q <= 1'b0;
      net_data_q  <= '0;
      net_cmd_q   <= '0;
      net_en_q    <= 1'b0;
      grant_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      net_valid_q <= net_valid_d;
      net_data_q  <= net_data_d;
      net_cmd_q   <= net_cmd_d;
      net_en_q    <= net_en_d;
      grant_q     <= grant_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_net_valid = net_valid_q;
  assign o_net_data  = net_data_q;
  assign o_net_cmd   = net_cmd_q;
  assign o_net_en    = net_en_q;
  assign o_grant_id  = grant_q;
  assign o_err       = err_q;
  assign o_issue_cnt = cnt_q;

endmodule
